// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among NUM_REQ byte streams
// Optional packet lock: define UART_ARB_PKT_LOCK_EN to keep the grant until a byte with req_last.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      arb_active
);

    localparam int SW = ID_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                tx_start_d;
    logic [NUM_REQ-1:0]  req_ready_d;
    logic [DATA_W-1:0]   tx_data_d;
    logic [ID_W-1:0]     grant_id_d;
    logic                arb_active_d;
    logic [DATA_W-1:0]   req_bytes [NUM_REQ];
    logic                found;
    logic [ID_W-1:0]     sel;
    logic                do_launch;
    logic [ID_W-1:0]     launch_id;
    logic [ID_W-1:0]     rr_next;

`ifdef UART_ARB_PKT_LOCK_EN
    logic last_q, last_d;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] sum;
        found = 1'b0;
        sel   = '0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr_q} + SW'(i);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            if (!found && req_valid[sum[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = sum[ID_W-1:0];
            end
        end
    end

    assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        tx_start_d   = 1'b0;
        req_ready_d  = '0;
        tx_data_d    = tx_data;
        grant_id_d   = grant_id;
        arb_active_d = arb_active;
        do_launch    = 1'b0;
        launch_id    = grant_id;
`ifdef UART_ARB_PKT_LOCK_EN
        last_d       = last_q;
`endif
        case (state_q)
            IDLE: begin
                // A transmit started elsewhere must finish before we launch.
                if (found && !tx_busy) begin
                    do_launch = 1'b1;
                    launch_id = sel;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    arb_active_d = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
                    if (!last_q) begin
                        state_d = LOCKED;
                    end else begin
                        rr_ptr_d = rr_next;
                        state_d  = IDLE;
                    end
`else
                    rr_ptr_d = rr_next;
                    state_d  = IDLE;
`endif
                end
            end
            LOCKED: begin
                if (req_valid[grant_id]) begin
                    do_launch = 1'b1;
                    launch_id = grant_id;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_launch) begin
            state_d                = LAUNCH;
            tx_start_d             = 1'b1;
            req_ready_d[launch_id] = 1'b1;
            tx_data_d              = req_bytes[launch_id];
            grant_id_d             = launch_id;
            arb_active_d           = 1'b1;
`ifdef UART_ARB_PKT_LOCK_EN
            last_d                 = req_last[launch_id];
`endif
        end
    end

    // rst_n is an active-high reset in this block.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            tx_start   <= 1'b0;
            req_ready  <= '0;
            tx_data    <= '0;
            grant_id   <= '0;
            arb_active <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_start   <= tx_start_d;
            req_ready  <= req_ready_d;
            tx_data    <= tx_data_d;
            grant_id   <= grant_id_d;
            arb_active <= arb_active_d;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q     <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [W-1:0]   tx_data;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           arb_active;

    int n_checks = 0;
    int n_fail   = 0;

    logic model_on  = 1'b0;
    logic lock_mode = 1'b0;
    int   busy_len  = 1;
    int   busy_left = 0;
    int   a_idx     = 0;
    logic b_done    = 1'b0;

    logic [7:0] lane_c [N];

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       busy;
        logic       start;
        logic [3:0] ready;
        logic [7:0] data;
        logic [1:0] gid;
        logic       act;
    } vec_t;

    vec_t tbl [20];

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_active (arb_active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_lock_lanes();
        logic [7:0] a_byte;
        a_byte    = 8'hA1 + 8'(a_idx);
        req_valid = {2'b00, !b_done, (a_idx < 3)};
        req_data  = {16'h0000, 8'hB1, a_byte};
        req_last  = {3'b000, (a_idx == 2)};
    endtask

    // One clock: the busy model and requesters react to what the DUT showed before the edge.
    task automatic step();
        logic         st;
        logic [N-1:0] rdy;
        st  = tx_start;
        rdy = req_ready;
        @(posedge clk);
        #1;
        if (model_on) begin
            if (st) busy_left = busy_len;
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
        if (lock_mode) begin
            if (rdy[0]) a_idx++;
            if (rdy[1]) b_done = 1'b1;
            set_lock_lanes();
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        busy_left = 0;
        step();
        rst_n = 1'b0;
    endtask

    task automatic wait_grant(input string nm, input int exp_gid, input int exp_gap);
        int k;
        k = 0;
        while (!tx_start && k < 60) begin
            step();
            k++;
        end
        if (!tx_start) begin
            check({nm, "_timeout"}, 32'(tx_start), 32'd1);
        end else begin
            check({nm, "_gid"}, 32'(grant_id), 32'(exp_gid));
            check({nm, "_ready"}, 32'(req_ready), 32'(1 << exp_gid));
            check({nm, "_data"}, 32'(tx_data), 32'(lane_c[exp_gid]));
            if (exp_gap >= 0) check({nm, "_gap"}, 32'(k), 32'(exp_gap));
        end
        step();
    endtask

    initial begin
        logic [7:0] got [4];
        logic [7:0] exp_order [4];
        int n_got;

        lane_c[0] = 8'hA0;
        lane_c[1] = 8'h55;
        lane_c[2] = 8'hC2;
        lane_c[3] = 8'hD3;
        rst_n     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        req_data  = {lane_c[3], lane_c[2], lane_c[1], lane_c[0]};

        //            rst   valid  busy  start  ready  data   gid    act
        tbl[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'h2, 1'b0, 1'b1, 4'h2, 8'h55, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h55, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h55, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 8'h55, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'h0, 8'h55, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 4'h1, 1'b0, 1'b0, 4'h0, 8'h55, 2'd1, 1'b0};
        tbl[8]  = '{1'b0, 4'h1, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b1};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'h8, 1'b1, 1'b0, 4'h0, 8'hA0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 4'h8, 1'b0, 1'b1, 4'h8, 8'hD3, 2'd3, 1'b1};
        tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'hD3, 2'd3, 1'b1};
        tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 8'hD3, 2'd3, 1'b1};
        tbl[17] = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 8'h00, 2'd0, 1'b0};
        tbl[19] = '{1'b0, 4'h3, 1'b0, 1'b1, 4'h1, 8'hA0, 2'd0, 1'b1};

        for (int r = 0; r < 20; r++) begin
            rst_n     = tbl[r].rst;
            req_valid = tbl[r].valid;
            tx_busy   = tbl[r].busy;
            step();
            check($sformatf("vec%0d_start", r), 32'(tx_start), 32'(tbl[r].start));
            check($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            check($sformatf("vec%0d_data", r), 32'(tx_data), 32'(tbl[r].data));
            check($sformatf("vec%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
            check($sformatf("vec%0d_act", r), 32'(arb_active), 32'(tbl[r].act));
        end

        // Fairness with all requesters valid, then a lone requester re-granted.
        tx_busy  = 1'b0;
        model_on = 1'b1;
        busy_len = 10;
        req_valid = 4'hF;
        do_reset();
        wait_grant("fair0", 0, -1);
        wait_grant("fair1", 1, 12);
        wait_grant("fair2", 2, 12);
        wait_grant("fair3", 3, 12);
        wait_grant("fair4", 0, 12);
        wait_grant("fair5", 1, 12);
        req_valid = 4'h2;
        wait_grant("single0", 1, 12);
        wait_grant("single1", 1, 12);

        // Pointer continuation after grant 3 and after grant 2, minimum spacing.
        busy_len  = 1;
        req_valid = 4'h8;
        do_reset();
        wait_grant("ptr_g3", 3, -1);
        req_valid = 4'h5;
        wait_grant("ptr_a0", 0, 3);
        wait_grant("ptr_b2", 2, 3);
        wait_grant("ptr_c0", 0, 3);

        // Packet lock ordering.
        req_valid = '0;
        busy_len  = 2;
        do_reset();
        a_idx     = 0;
        b_done    = 1'b0;
        lock_mode = 1'b1;
        set_lock_lanes();
        n_got = 0;
        for (int c = 0; c < 120 && n_got < 4; c++) begin
            step();
            if (tx_start) begin
                got[n_got] = tx_data;
                n_got++;
            end
        end
`ifdef UART_ARB_PKT_LOCK_EN
        exp_order[0] = 8'hA1;
        exp_order[1] = 8'hA2;
        exp_order[2] = 8'hA3;
        exp_order[3] = 8'hB1;
`else
        exp_order[0] = 8'hA1;
        exp_order[1] = 8'hB1;
        exp_order[2] = 8'hA2;
        exp_order[3] = 8'hA3;
`endif
        check("lock_count", 32'(n_got), 32'd4);
        for (int i = 0; i < n_got; i++) begin
            check($sformatf("lock_byte%0d", i), 32'(got[i]), 32'(exp_order[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
